spi_master: RTL and testbench
=============================

# spi_master

Single-byte SPI master supporting all four SPI modes, clocked from the system clock with a programmable divider. It accepts one parallel byte per valid/ready handshake and shifts it out MSB-first on MOSI while shifting a byte in from MISO. It sits between an on-chip controller and an off-chip SPI slave. Chip-select is handled outside this block.

## Interface
- SPI_MODE, 0: SPI mode 0–3; CPOL = mode 2/3, CPHA = mode 1/3.
- CLKS_PER_HALF_BIT, 2: system clocks per SPI clock half-period; legal values ≥ 2.

- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst  in  1  reset; one clock, synchronous, active-high.
- i_MOSI_Byte  in  8  byte to transmit; sampled on accept.
- i_MOSI_DV  in  1  transmit request; accepted only when o_MOSI_Ready=1.
- o_MOSI_Ready  out  1  high when idle and able to accept a byte.
- o_MISO_DV  out  1  one-cycle pulse: o_MISO_Byte updated.
- o_MISO_Byte  out  8  last received byte; held until next update.
- o_SPI_Clk  out  1  SPI clock; idles at CPOL.
- i_SPI_MISO  in  1  serial data from slave.
- o_SPI_MOSI  out  1  serial data to slave, MSB first.

## Operation
- Reset values: o_MOSI_Ready=1, o_MISO_DV=0, o_MISO_Byte=0x00, o_SPI_Clk=CPOL, o_SPI_MOSI=0. Internal counters and shift registers are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE to SHIFT: in cycle T, i_MOSI_DV=1 and o_MOSI_Ready=1. The byte is latched, and o_MOSI_Ready=0 from T+1.
- In IDLE, i_MOSI_DV=0 causes no change.
- While busy (o_MOSI_Ready=0), i_MOSI_DV is ignored and the latched byte is unaffected.
- SHIFT generates exactly 16 SPI clock edges. Odd-numbered edges are leading edges; even-numbered edges are trailing edges.
- CPHA=0:
  - Bit 7 is on o_SPI_MOSI from T+1.
  - i_SPI_MISO is sampled on each leading edge.
  - MOSI advances to the next bit on each trailing edge, except edge 16.
- CPHA=1:
  - MOSI presents bit 7 at edge 1 and the next bit on each subsequent leading edge.
  - i_SPI_MISO is sampled on each trailing edge.
- Received bits shift in MSB first.
- On the 8th sample, o_MISO_Byte is loaded with the full byte and o_MISO_DV pulses for exactly one cycle.
- SHIFT to DONE after edge 16. DONE to IDLE on the next cycle, where o_MOSI_Ready returns to 1.
- o_MISO_Byte is always valid before or in the same cycle that o_MOSI_Ready rises.
- o_SPI_MOSI holds its last driven bit while idle.
- Loopback (o_SPI_MOSI tied to i_SPI_MISO) must return the transmitted byte in every mode.
- Reset asserted mid-transfer aborts immediately and restores all reset values. o_MISO_DV is not pulsed.

## Timing
- Let N = CLKS_PER_HALF_BIT.
- Edge k (1..16) is visible on o_SPI_Clk at cycle T+1+k·N.
- Sampling happens on the same clock as the corresponding edge.
- o_MISO_DV timing:
  - CPHA=0: pulse at cycle T+2+15N.
  - CPHA=1: pulse at cycle T+2+16N.
- o_MOSI_Ready=1 at cycle T+2+16N+1. The transfer occupies 16N+2 cycles from accept to ready.
- Back-to-back: a request held high while o_MOSI_Ready rises is accepted in the first ready cycle.
- o_SPI_Clk is exactly CPOL in IDLE and DONE, so no glitch edges occur.

## Structure
- Shared package spi_pkg holds:
  - CPOL/CPHA decode functions for SPI_MODE.
  - The edge-count constant 16.
  - State encoding IDLE/SHIFT/DONE.
- One natural sub-module: spi_clk_gen.
  - Contains the half-bit divider and edge counter.
  - Outputs o_SPI_Clk plus one-cycle leading/trailing edge strobes and a busy flag.
- The top level holds the handshake, TX/RX shift registers and bit indices.

## Test plan
- Mode 0, N=2, loopback: send 0x75 then 0x39.
  - o_MISO_Byte = 0x75 then 0x39 at each rising edge of o_MOSI_Ready.
  - Exactly one o_MISO_DV pulse per byte.
- Modes 1, 2, 3 loopback with 0xA5, 0x00, 0xFF:
  - Received byte equals sent byte.
  - o_SPI_Clk idles at CPOL before and after each transfer.
- Timing check, mode 0, N=4:
  - 16 o_SPI_Clk toggles, spaced 4 cycles apart.
  - o_MOSI_Ready low for exactly 16·4+2 cycles after accept.
- Busy rejection:
  - Assert i_MOSI_DV with 0x12 mid-transfer of 0x75.
  - 0x75 completes unchanged, 0x12 is never sent, only one o_MISO_DV pulse.
- Reset mid-transfer at edge 5:
  - Outputs return to reset values next cycle (o_MOSI_Ready=1, o_SPI_Clk=CPOL, o_MISO_Byte=0x00).
  - A following send of 0x3C returns 0x3C.
- Slave model with MISO driven independently: master sends 0x5A while slave returns 0xC3.
  - o_MISO_Byte=0xC3, and MOSI is captured MSB-first as 0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Purpose: shared constants, state encoding and mode decode for the SPI master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: EDGE_COUNT, spi_state_t, cpol_of(), cpha_of().
package spi_pkg;

  // Each byte is framed by 16 SPI clock edges: 8 leading and 8 trailing.
  localparam int EDGE_COUNT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  // Modes 2 and 3 idle the clock high.
  function automatic logic cpol_of(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  // Modes 1 and 3 sample on the trailing edge.
  function automatic logic cpha_of(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Purpose: half-bit divider and edge counter that produce SPI clock and edge strobes.
// Latency: edge k appears on o_SPI_Clk k*N cycles after busy rises; strobes lead it by one cycle.
// Backpressure: i_start is ignored while busy.
// Ports: i_Clk/i_Rst system clock and sync reset; i_start begins a 16-edge burst;
//        o_SPI_Clk SPI clock (idles at CPOL); o_lead/o_trail one-cycle strobes in the
//        cycle before the matching edge becomes visible; o_busy high during the burst.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_start,
  output logic o_SPI_Clk,
  output logic o_lead,
  output logic o_trail,
  output logic o_busy
);

  localparam logic P_CPOL = cpol_of(SPI_MODE);
  localparam int   CW     = $clog2(CLKS_PER_HALF_BIT);

  logic [CW-1:0] r_half_cnt;
  logic [4:0]    r_edge_cnt;
  logic          r_busy;
  logic          r_spi_clk;
  logic          w_tick;

  // The tick is the last cycle of a half period: the register update at the end
  // of it makes the edge visible, so anything sampling on the strobe lines up
  // with the same system clock edge as the SPI clock transition.
  assign w_tick  = r_busy && (r_half_cnt == CW'(CLKS_PER_HALF_BIT - 1));
  assign o_lead  = w_tick && !r_edge_cnt[0];
  assign o_trail = w_tick &&  r_edge_cnt[0];

  assign o_SPI_Clk = r_spi_clk;
  assign o_busy    = r_busy;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_half_cnt <= '0;
      r_edge_cnt <= '0;
      r_busy     <= 1'b0;
      r_spi_clk  <= P_CPOL;
    end else if (!r_busy) begin
      r_half_cnt <= '0;
      r_edge_cnt <= '0;
      r_spi_clk  <= P_CPOL;
      if (i_start) begin
        r_busy <= 1'b1;
      end
    end else if (w_tick) begin
      r_half_cnt <= '0;
      r_spi_clk  <= ~r_spi_clk;
      r_edge_cnt <= r_edge_cnt + 5'd1;
      if (r_edge_cnt == 5'(EDGE_COUNT - 1)) begin
        r_busy <= 1'b0;
      end
    end else begin
      r_half_cnt <= r_half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Purpose: single-byte SPI master, all four modes, MSB first, valid/ready byte input.
// Latency: 16*N+2 cycles from accept to o_MOSI_Ready; o_MISO_DV at T+2+15N (CPHA=0) or T+2+16N (CPHA=1).
// Backpressure: o_MOSI_Ready low while busy; requests during that time are dropped.
// Ports: i_Clk/i_Rst system clock and sync active-high reset; i_MOSI_Byte/i_MOSI_DV/
//        o_MOSI_Ready transmit handshake; o_MISO_Byte/o_MISO_DV received byte and strobe;
//        o_SPI_Clk/o_SPI_MOSI/i_SPI_MISO serial pins (chip-select is external).
module spi_master
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_MOSI_Byte,
  input  logic       i_MOSI_DV,
  output logic       o_MOSI_Ready,
  output logic       o_MISO_DV,
  output logic [7:0] o_MISO_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);

  localparam logic P_CPHA = cpha_of(SPI_MODE);

  spi_state_t r_state;
  spi_state_t w_next_state;

  logic       w_ready;
  logic       w_accept;
  logic       w_lead;
  logic       w_trail;
  logic       w_busy;
  logic       w_sample;
  logic       w_advance;

  logic [7:0] r_tx_byte;
  logic [3:0] r_tx_idx;   // bit 3 set means every bit has been presented
  logic [7:0] r_rx_shift;
  logic [3:0] r_rx_cnt;
  logic       r_rx_full;

  spi_clk_gen #(
    .SPI_MODE          (SPI_MODE),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
  ) u_clk_gen (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_start   (w_accept),
    .o_SPI_Clk (o_SPI_Clk),
    .o_lead    (w_lead),
    .o_trail   (w_trail),
    .o_busy    (w_busy)
  );

  assign w_sample     = P_CPHA ? w_trail : w_lead;
  assign w_advance    = P_CPHA ? w_lead  : w_trail;
  assign w_accept     = w_ready && i_MOSI_DV;
  assign o_MOSI_Ready = w_ready;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (i_MOSI_DV) begin
          w_next_state = SHIFT;
        end
      end
      // The clock generator is already busy in the first SHIFT cycle; it drops
      // busy together with edge 16.
      SHIFT:   if (!w_busy) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_tx_byte   <= '0;
      r_tx_idx    <= '0;
      r_rx_shift  <= '0;
      r_rx_cnt    <= '0;
      r_rx_full   <= 1'b0;
      o_SPI_MOSI  <= 1'b0;
      o_MISO_Byte <= '0;
      o_MISO_DV   <= 1'b0;
    end else begin
      o_MISO_DV <= 1'b0;
      r_rx_full <= 1'b0;

      if (w_accept) begin
        r_tx_byte <= i_MOSI_Byte;
        r_rx_cnt  <= '0;
        if (!P_CPHA) begin
          // CPHA=0 needs bit 7 on the wire before the first leading edge.
          o_SPI_MOSI <= i_MOSI_Byte[7];
          r_tx_idx   <= 4'd6;
        end else begin
          r_tx_idx <= 4'd7;
        end
      end

      // Once the index wraps past bit 0 further advance strobes (edge 16 in
      // CPHA=0) leave MOSI holding the last bit.
      if (w_advance && !r_tx_idx[3]) begin
        o_SPI_MOSI <= r_tx_byte[r_tx_idx[2:0]];
        r_tx_idx   <= r_tx_idx - 4'd1;
      end

      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[6:0], i_SPI_MISO};
        r_rx_cnt   <= r_rx_cnt + 4'd1;
        if (r_rx_cnt == 4'd7) begin
          r_rx_full <= 1'b1;
        end
      end

      if (r_rx_full) begin
        o_MISO_Byte <= r_rx_shift;
        o_MISO_DV   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dv   [5];
  logic [7:0] txb  [5];
  logic       rdy  [5];
  logic       mdv  [5];
  logic [7:0] rxb  [5];
  logic       sclk [5];
  logic       miso [5];
  logic       mosi [5];

  // idle clock level per instance: u2 and u3 run modes 2 and 3
  localparam logic [4:0] CPOL_V = 5'b01100;

  int total  = 0;
  int passed = 0;

  // independent slave on u0
  logic       slave_en = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  int         slave_idx = 7;
  logic [7:0] slave_rx = 8'h00;

  assign miso[0] = slave_en ? slave_byte[slave_idx[2:0]] : mosi[0];
  assign miso[1] = mosi[1];
  assign miso[2] = mosi[2];
  assign miso[3] = mosi[3];
  assign miso[4] = mosi[4];

  spi_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) u0 (
    .i_Clk(clk), .i_Rst(rst), .i_MOSI_Byte(txb[0]), .i_MOSI_DV(dv[0]),
    .o_MOSI_Ready(rdy[0]), .o_MISO_DV(mdv[0]), .o_MISO_Byte(rxb[0]),
    .o_SPI_Clk(sclk[0]), .i_SPI_MISO(miso[0]), .o_SPI_MOSI(mosi[0]));
  spi_master #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(2)) u1 (
    .i_Clk(clk), .i_Rst(rst), .i_MOSI_Byte(txb[1]), .i_MOSI_DV(dv[1]),
    .o_MOSI_Ready(rdy[1]), .o_MISO_DV(mdv[1]), .o_MISO_Byte(rxb[1]),
    .o_SPI_Clk(sclk[1]), .i_SPI_MISO(miso[1]), .o_SPI_MOSI(mosi[1]));
  spi_master #(.SPI_MODE(2), .CLKS_PER_HALF_BIT(3)) u2 (
    .i_Clk(clk), .i_Rst(rst), .i_MOSI_Byte(txb[2]), .i_MOSI_DV(dv[2]),
    .o_MOSI_Ready(rdy[2]), .o_MISO_DV(mdv[2]), .o_MISO_Byte(rxb[2]),
    .o_SPI_Clk(sclk[2]), .i_SPI_MISO(miso[2]), .o_SPI_MOSI(mosi[2]));
  spi_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(2)) u3 (
    .i_Clk(clk), .i_Rst(rst), .i_MOSI_Byte(txb[3]), .i_MOSI_DV(dv[3]),
    .o_MOSI_Ready(rdy[3]), .o_MISO_DV(mdv[3]), .o_MISO_Byte(rxb[3]),
    .o_SPI_Clk(sclk[3]), .i_SPI_MISO(miso[3]), .o_SPI_MOSI(mosi[3]));
  spi_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(4)) u4 (
    .i_Clk(clk), .i_Rst(rst), .i_MOSI_Byte(txb[4]), .i_MOSI_DV(dv[4]),
    .o_MOSI_Ready(rdy[4]), .o_MISO_DV(mdv[4]), .o_MISO_Byte(rxb[4]),
    .o_SPI_Clk(sclk[4]), .i_SPI_MISO(miso[4]), .o_SPI_MOSI(mosi[4]));

  // monitors, sampled on the falling edge
  int   dv_cnt [5] = '{0, 0, 0, 0, 0};
  int   cyc = 0;
  int   tog_n = 0;
  int   tog_cyc [64];
  int   dv_cyc4 = 0;
  int   rdy_cyc4 = 0;
  logic prev_sclk4 = 1'b0;
  logic prev_rdy4 = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 5; i++) if (mdv[i] === 1'b1) dv_cnt[i] = dv_cnt[i] + 1;
    if (sclk[4] !== prev_sclk4) begin
      if (tog_n < 64) tog_cyc[tog_n] = cyc;
      tog_n = tog_n + 1;
    end
    prev_sclk4 = sclk[4];
    if (mdv[4] === 1'b1) dv_cyc4 = cyc;
    if (rdy[4] === 1'b1 && prev_rdy4 !== 1'b1) rdy_cyc4 = cyc;
    prev_rdy4 = rdy[4];
  end

  // mode 0 slave: capture MOSI on leading (rising) edge, shift MISO on trailing edge
  always @(posedge sclk[0]) if (slave_en) slave_rx = {slave_rx[6:0], mosi[0]};
  always @(negedge sclk[0]) if (slave_en && slave_idx > 0) slave_idx = slave_idx - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send(input int i, input logic [7:0] b, output logic [7:0] rx, output int low);
    @(negedge clk);
    check($sformatf("ready_before[%0d]", i), {31'd0, rdy[i]}, 32'd1);
    check($sformatf("cpol_before[%0d]", i), {31'd0, sclk[i]}, {31'd0, CPOL_V[i]});
    txb[i] = b;
    dv[i]  = 1'b1;
    @(negedge clk);
    dv[i] = 1'b0;
    low = 0;
    while (rdy[i] !== 1'b1 && low < 1000) begin
      low = low + 1;
      @(negedge clk);
    end
    check($sformatf("ready_timeout[%0d]", i), {31'd0, rdy[i]}, 32'd1);
    rx = rxb[i];
    check($sformatf("cpol_after[%0d]", i), {31'd0, sclk[i]}, {31'd0, CPOL_V[i]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] pats [3];
    int         low;
    int         base;
    int         bad;

    pats = '{8'hA5, 8'h00, 8'hFF};
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dv[i]  = 1'b0;
      txb[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset values, and idle with DV low changes nothing
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_ready[%0d]", i), {31'd0, rdy[i]}, 32'd1);
      check($sformatf("rst_miso_dv[%0d]", i), {31'd0, mdv[i]}, 32'd0);
      check($sformatf("rst_miso_byte[%0d]", i), {24'd0, rxb[i]}, 32'd0);
      check($sformatf("rst_mosi[%0d]", i), {31'd0, mosi[i]}, 32'd0);
      check($sformatf("rst_sclk[%0d]", i), {31'd0, sclk[i]}, {31'd0, CPOL_V[i]});
    end

    // mode 0, N=2 loopback
    send(0, 8'h75, rx, low);
    check("m0_rx_75", {24'd0, rx}, 32'h75);
    check("m0_low_cycles", low, 34);
    check("m0_dv_count_1", dv_cnt[0], 1);
    send(0, 8'h39, rx, low);
    check("m0_rx_39", {24'd0, rx}, 32'h39);
    check("m0_dv_count_2", dv_cnt[0], 2);

    // modes 1..3 loopback
    for (int i = 1; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        send(i, pats[k], rx, low);
        check($sformatf("loop_rx[m%0d,%0d]", i, k), {24'd0, rx}, {24'd0, pats[k]});
      end
      check($sformatf("loop_dv_count[m%0d]", i), dv_cnt[i], 3);
    end

    // timing, mode 0, N=4
    base = tog_n;
    send(4, 8'hC6, rx, low);
    #1;
    check("t_rx", {24'd0, rx}, 32'hC6);
    check("t_low_cycles", low, 66);
    check("t_toggles", tog_n - base, 16);
    bad = 0;
    for (int k = 1; k < 16; k++)
      if (base + k < 64 && tog_cyc[base + k] - tog_cyc[base + k - 1] != 4) bad = bad + 1;
    check("t_spacing_bad", bad, 0);
    check("t_edge1_to_ready", rdy_cyc4 - tog_cyc[base], 62);
    check("t_dv_to_ready", rdy_cyc4 - dv_cyc4, 5);

    // busy rejection on u0
    base = dv_cnt[0];
    @(negedge clk);
    txb[0] = 8'h75;
    dv[0]  = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (8) @(negedge clk);
    txb[0] = 8'h12;
    dv[0]  = 1'b1;
    repeat (3) @(negedge clk);
    dv[0] = 1'b0;
    check("busy_ready_low", {31'd0, rdy[0]}, 32'd0);
    low = 0;
    while (rdy[0] !== 1'b1 && low < 1000) begin
      low = low + 1;
      @(negedge clk);
    end
    check("busy_rx_75", {24'd0, rxb[0]}, 32'h75);
    check("busy_dv_once", dv_cnt[0] - base, 1);
    repeat (10) @(negedge clk);
    check("busy_no_second", {31'd0, rdy[0]}, 32'd1);
    check("busy_dv_still_once", dv_cnt[0] - base, 1);

    // reset at edge 5
    base = dv_cnt[0];
    txb[0] = 8'h81;
    dv[0]  = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_edge5_high", {31'd0, sclk[0]}, 32'd1);
    check("mid_busy", {31'd0, rdy[0]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", {31'd0, rdy[0]}, 32'd1);
    check("mid_rst_sclk", {31'd0, sclk[0]}, 32'd0);
    check("mid_rst_byte", {24'd0, rxb[0]}, 32'd0);
    check("mid_rst_mosi", {31'd0, mosi[0]}, 32'd0);
    repeat (40) @(negedge clk);
    check("mid_no_dv", dv_cnt[0] - base, 0);
    send(0, 8'h3C, rx, low);
    check("mid_after_rx_3c", {24'd0, rx}, 32'h3C);

    // independent slave
    slave_byte = 8'hC3;
    slave_idx  = 7;
    slave_rx   = 8'h00;
    slave_en   = 1'b1;
    send(0, 8'h5A, rx, low);
    slave_en = 1'b0;
    check("slave_miso_c3", {24'd0, rx}, 32'hC3);
    check("slave_saw_5a", {24'd0, slave_rx}, 32'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
